vga_frame_timing: RTL and testbench

- Programmable VGA raster timing generator feeding the pixel/draw pipeline inside top.
- Produces the hs/vs that drive the display pins and the frame-capture writer.
- Default geometry is 800x600 visible in a 1056x628 total raster.
- Adds a pixel-enable gate, a start-of-frame pulse and a frame counter for downstream game logic (puck/paddle update once per frame).

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_window_cmp.sv | 27 ++
 rtl/vga_frame_timing.sv | 96 +++++++++
 tb/tb_vga_frame_timing.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster geometry for the VGA timing generator: default 800x600 timing
// in a 1056x628 raster, derived totals and sync windows, and the counter width.
package vga_timing_pkg;

    localparam int COUNT_W = 11;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    // Last position of an inclusive window that starts at 'start' and spans 'len'.
    function automatic int win_end(input int start, input int len);
        return start + len - 1;
    endfunction

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = win_end(DEF_HS_START, DEF_H_SYNC);
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = win_end(DEF_VS_START, DEF_V_SYNC);

endpackage

// File: rtl/vga_window_cmp.sv
// Registered inclusive range comparator: level = pol while lo <= value <= hi,
// otherwise ~pol. Fed with next-count values so the output lines up with the counters.
module vga_window_cmp
    import vga_timing_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [COUNT_W-1:0] value,
    input  logic [COUNT_W-1:0] lo,
    input  logic [COUNT_W-1:0] hi,
    input  logic               pol,
    output logic               level
);

    logic in_win;

    assign in_win = (value >= lo) && (value <= hi);

    always_ff @(posedge clk) begin
        if (!rst)
            level <= ~pol;
        else if (en)
            level <= in_win ? pol : ~pol;
    end

endmodule

// File: rtl/vga_frame_timing.sv
// Programmable VGA raster generator: column/line counters with registered blank,
// sync, start-of-frame and frame-count outputs, all aligned to hcount/vcount.
module vga_frame_timing
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [COUNT_W-1:0] hcount,
    output logic [COUNT_W-1:0] vcount,
    output logic               hblnk,
    output logic               vblnk,
    output logic               hsync,
    output logic               vsync,
    output logic               sof,
    output logic [15:0]        frame_cnt
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = win_end(HS_START, H_SYNC);
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = win_end(VS_START, V_SYNC);

    localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_geometry
        $error("vga_frame_timing: raster exceeds 11-bit counters");
    end

    logic               h_last, v_last, frame_wrap;
    logic [COUNT_W-1:0] h_nxt, v_nxt;

    always_comb begin
        h_last     = (hcount == H_LAST);
        v_last     = (vcount == V_LAST);
        frame_wrap = h_last && v_last;
        h_nxt      = h_last ? '0 : hcount + 1'b1;
        v_nxt      = vcount;
        if (h_last)
            v_nxt = v_last ? '0 : vcount + 1'b1;
    end

    // A forced restart through reset clears sof rather than pulsing it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount    <= '0;
            vcount    <= '0;
            sof       <= 1'b0;
            frame_cnt <= '0;
        end else if (en) begin
            hcount <= h_nxt;
            vcount <= v_nxt;
            sof    <= frame_wrap;
            if (frame_wrap)
                frame_cnt <= frame_cnt + 16'd1;
        end else begin
            sof <= 1'b0;
        end
    end

    // Decoders see next-count values so their registered outputs match the counters.
    vga_window_cmp u_hblnk (
        .clk(clk), .rst(rst), .en(en), .value(h_nxt),
        .lo(COUNT_W'(H_ACTIVE)), .hi(H_LAST), .pol(1'b1), .level(hblnk)
    );

    vga_window_cmp u_vblnk (
        .clk(clk), .rst(rst), .en(en), .value(v_nxt),
        .lo(COUNT_W'(V_ACTIVE)), .hi(V_LAST), .pol(1'b1), .level(vblnk)
    );

    vga_window_cmp u_hsync (
        .clk(clk), .rst(rst), .en(en), .value(h_nxt),
        .lo(COUNT_W'(HS_START)), .hi(COUNT_W'(HS_END)), .pol(HS_POL), .level(hsync)
    );

    vga_window_cmp u_vsync (
        .clk(clk), .rst(rst), .en(en), .value(v_nxt),
        .lo(COUNT_W'(VS_START)), .hi(COUNT_W'(VS_END)), .pol(VS_POL), .level(vsync)
    );

endmodule

// File: tb/tb_vga_frame_timing.sv
// Bench for vga_frame_timing: shortened 16x10 raster with a scoreboard model,
// a vector table of counter checkpoints, and a 1x1 raster for frame_cnt wrap.
module tb_vga_frame_timing;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 6, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;   // 16
    localparam int VT = VA + VF + VSW + VB;   // 10

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic        hs;
        logic        vs;
        logic        sf;
        logic [15:0] fc;
    } exp_t;

    typedef struct {
        logic rst;
        logic en;
        int   n;
        int   h;
        int   v;
        int   fc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, en, en2;
    logic [10:0] hcount, vcount, hcount2, vcount2;
    logic        hblnk, vblnk, hsync, vsync, sof;
    logic        hblnk2, vblnk2, hsync2, vsync2, sof2;
    logic [15:0] frame_cnt, frame_cnt2;

    int   n_pass = 0, n_total = 0;
    int   mh = 0, mv = 0;
    logic [15:0] mfc = '0;
    logic msof = 1'b0;
    exp_t sb[$];
    vec_t tbl[11];

    always #5 clk = ~clk;

    vga_frame_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .hcount(hcount), .vcount(vcount),
        .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
        .sof(sof), .frame_cnt(frame_cnt)
    );

    // 1x1 raster: every enabled clock completes a frame.
    vga_frame_timing #(
        .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
        .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut2 (
        .clk(clk), .rst(rst), .en(en2), .hcount(hcount2), .vcount(vcount2),
        .hblnk(hblnk2), .vblnk(vblnk2), .hsync(hsync2), .vsync(vsync2),
        .sof(sof2), .frame_cnt(frame_cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.h  = 11'(mh);
        x.v  = 11'(mv);
        x.hb = (mh >= HA);
        x.vb = (mv >= VA);
        x.hs = (mh >= HA + HF && mh <= HA + HF + HSW - 1);
        x.vs = !(mv >= VA + VF && mv <= VA + VF + VSW - 1);
        x.sf = msof;
        x.fc = mfc;
        return x;
    endfunction

    task automatic step(input logic r, input logic e);
        exp_t a, x;
        rst = r;
        en  = e;
        if (!r) begin
            mh = 0; mv = 0; mfc = '0; msof = 1'b0;
        end else if (e) begin
            msof = (mh == HT - 1) && (mv == VT - 1);
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
            if (msof) mfc++;
        end else begin
            msof = 1'b0;
        end
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        a = '{hcount, vcount, hblnk, vblnk, hsync, vsync, sof, frame_cnt};
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            x = sb.pop_front();
            chk("scoreboard", 64'(a), 64'(x));
        end
    endtask

    initial begin
        int hs_n, vs_n, vb_n, hb_n, sof_n, viol, cyc;
        logic vs_prev;
        logic seen;

        rst = 1'b0; en = 1'b0; en2 = 1'b0;

        tbl[0]  = '{1'b1, 1'b1, 1,   1,  0, 0};
        tbl[1]  = '{1'b1, 1'b1, 14,  15, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1,   0,  1, 0};
        tbl[3]  = '{1'b1, 1'b0, 7,   0,  1, 0};
        tbl[4]  = '{1'b1, 1'b1, 143, 15, 9, 0};
        tbl[5]  = '{1'b1, 1'b1, 1,   0,  0, 1};
        tbl[6]  = '{1'b1, 1'b1, 37,  5,  2, 1};
        tbl[7]  = '{1'b0, 1'b1, 1,   0,  0, 0};
        tbl[8]  = '{1'b0, 1'b0, 2,   0,  0, 0};
        tbl[9]  = '{1'b1, 1'b1, 160, 0,  0, 1};
        tbl[10] = '{1'b1, 1'b1, 480, 0,  0, 4};

        // Reset held with en high.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        chk("reset_hcount", 64'(hcount), 64'd0);
        chk("reset_hsync", 64'(hsync), 64'd0);
        chk("reset_vsync", 64'(vsync), 64'd1);
        chk("reset_fc", 64'(frame_cnt), 64'd0);

        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rst, tbl[i].en);
            chk($sformatf("tbl%0d_h", i), 64'(hcount), 64'(tbl[i].h));
            chk($sformatf("tbl%0d_v", i), 64'(vcount), 64'(tbl[i].v));
            chk($sformatf("tbl%0d_fc", i), 64'(frame_cnt), 64'(tbl[i].fc));
        end

        // One full frame: window widths and vsync edges only at line start.
        hs_n = 0; vs_n = 0; vb_n = 0; hb_n = 0; sof_n = 0; viol = 0;
        vs_prev = vsync;
        for (int i = 0; i < HT * VT; i++) begin
            step(1'b1, 1'b1);
            hs_n  += int'(hsync);
            vs_n  += int'(!vsync);
            vb_n  += int'(vblnk);
            hb_n  += int'(hblnk);
            sof_n += int'(sof);
            if (vsync !== vs_prev && hcount != 0) viol++;
            vs_prev = vsync;
        end
        chk("frame_hsync_cycles", 64'(hs_n), 64'(HSW * VT));
        chk("frame_vsync_cycles", 64'(vs_n), 64'(VSW * HT));
        chk("frame_vblnk_cycles", 64'(vb_n), 64'((VT - VA) * HT));
        chk("frame_hblnk_cycles", 64'(hb_n), 64'((HT - HA) * VT));
        chk("frame_sof_pulses", 64'(sof_n), 64'd1);
        chk("vsync_edge_align", 64'(viol), 64'd0);
        chk("frame_fc", 64'(frame_cnt), 64'd5);

        // Stall 7 cycles at hcount=5: frame period stretches to HT*VT+7.
        cyc = 0;
        for (int i = 0; i < 5; i++) begin step(1'b1, 1'b1); cyc++; end
        for (int i = 0; i < 7; i++) begin step(1'b1, 1'b0); cyc++; end
        chk("stall_hold_h", 64'(hcount), 64'd5);
        step(1'b1, 1'b1); cyc++;
        chk("stall_resume_h", 64'(hcount), 64'd6);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step(1'b1, 1'b1); cyc++;
            if (sof) seen = 1'b1;
        end
        chk("stall_sof_seen", 64'(seen), 64'd1);
        chk("stall_period", 64'(cyc), 64'(HT * VT + 7));

        // Mid-frame reset: back to origin, no sof, count cleared.
        for (int i = 0; i < 3 * HT + 4; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("midrst_sof", 64'(sof), 64'd0);
        chk("midrst_h", 64'(hcount), 64'd0);
        step(1'b1, 1'b1);
        chk("midrst_restart_h", 64'(hcount), 64'd1);

        // frame_cnt wrap on the 1x1 raster; main DUT idles with en low.
        rst = 1'b1; en = 1'b0;
        chk("wrap_start_fc", 64'(frame_cnt2), 64'd0);
        en2 = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_fc_ffff", 64'(frame_cnt2), 64'hFFFF);
        @(posedge clk);
        #1;
        chk("wrap_fc_zero", 64'(frame_cnt2), 64'd0);
        chk("wrap_sof", 64'(sof2), 64'd1);
        en2 = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap_hold_sof", 64'(sof2), 64'd0);
        chk("wrap_hold_fc", 64'(frame_cnt2), 64'd0);
        chk("idle_main_h", 64'(hcount), 64'(mh));
        chk("idle_main_sof", 64'(sof), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
